// File: rtl/bus_pkg.sv
// Shared types and constants for the N-port bus arbiter.
// Holds the FSM state encoding and the priority-mode selectors.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;

endpackage

// File: rtl/bus_arbiter_n_rr_picker.sv
// Combinational winner select: the first requesting port at or after the base index.
// In fixed mode the base is pinned to 0, so the lowest requesting index wins.
module rr_picker
    import bus_pkg::*;
#(
    parameter int NPORTS = 4,
    parameter int MODE   = MODE_RR,
    localparam int IW    = $clog2(NPORTS)
) (
    input  logic [NPORTS-1:0] request,
    input  logic [IW-1:0]     ptr,
    output logic [IW-1:0]     index,
    output logic              valid
);

    logic [IW-1:0]     base;
    logic [NPORTS-1:0] rot_req;
    logic [IW-1:0]     rot_idx [NPORTS];

    assign base = (MODE == MODE_RR) ? ptr : '0;

    // Rotate the request vector so that position 0 is the base port.
    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rot
        logic [IW:0] sum;
        assign sum         = {1'b0, base} + (IW+1)'(gi);
        assign rot_idx[gi] = (sum >= (IW+1)'(NPORTS)) ? IW'(sum - (IW+1)'(NPORTS)) : IW'(sum);
        assign rot_req[gi] = request[rot_idx[gi]];
    end

    always_comb begin
        valid = 1'b0;
        index = '0;
        for (int k = NPORTS - 1; k >= 0; k--) begin
            if (rot_req[k]) begin
                valid = 1'b1;
                index = rot_idx[k];
            end
        end
    end

endmodule

// File: rtl/bus_arbiter_n.sv
// N-port four-phase bus arbiter: grants one master, replays its access downstream,
// returns read data per port and aborts stalled accesses with a watchdog.
module bus_arbiter_n
    import bus_pkg::*;
#(
    parameter int                NPORTS       = 4,
    parameter int                ADDR_W       = 32,
    parameter int                DATA_W       = 32,
    parameter int                MODE         = MODE_RR,
    parameter int                TIMEOUT      = 1024,
    parameter logic [DATA_W-1:0] TIMEOUT_DATA = DATA_W'(32'hDEADBEEF)
) (
    input  logic                       i_clock,
    input  logic                       i_reset_n,
    input  logic [NPORTS-1:0]          i_request,
    input  logic [NPORTS-1:0]          i_rw,
    input  logic [NPORTS*ADDR_W-1:0]   i_address,
    input  logic [NPORTS*DATA_W-1:0]   i_wdata,
    output logic [NPORTS*DATA_W-1:0]   o_rdata,
    output logic [NPORTS-1:0]          o_ready,
    output logic [NPORTS-1:0]          o_busy,
    output logic                       o_bus_request,
    output logic                       o_bus_rw,
    output logic [ADDR_W-1:0]          o_bus_address,
    output logic [DATA_W-1:0]          o_bus_wdata,
    input  logic                       i_bus_ready,
    input  logic [DATA_W-1:0]          i_bus_rdata,
    output logic                       o_timeout
);

    localparam int IW = $clog2(NPORTS);
    localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t             state_reg, state_next;
    logic [IW-1:0]      grant_reg;
    logic [IW-1:0]      ptr_reg;
    logic [IW-1:0]      ptr_next;
    logic               rw_reg;
    logic [ADDR_W-1:0]  addr_reg;
    logic [DATA_W-1:0]  wdata_reg;
    logic [TW-1:0]      timer_reg;
    logic               timeout_reg;
    logic [DATA_W-1:0]  rdata_reg [NPORTS];

    logic [IW-1:0]      pick_idx;
    logic               pick_valid;
    logic               timeout_hit;

    rr_picker #(
        .NPORTS (NPORTS),
        .MODE   (MODE)
    ) u_picker (
        .request (i_request),
        .ptr     (ptr_reg),
        .index   (pick_idx),
        .valid   (pick_valid)
    );

    // Abort on the edge that would bring the timer up to TIMEOUT.
    assign timeout_hit = (TIMEOUT != 0) && (timer_reg == TW'(TIMEOUT - 1));
    assign ptr_next    = (grant_reg == IW'(NPORTS - 1)) ? '0 : grant_reg + 1'b1;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (pick_valid) state_next = BUS;
            BUS:     if (i_bus_ready || timeout_hit) state_next = ACK;
            ACK:     if (!i_request[grant_reg]) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            grant_reg   <= '0;
            ptr_reg     <= '0;
            rw_reg      <= 1'b0;
            addr_reg    <= '0;
            wdata_reg   <= '0;
            timer_reg   <= '0;
            timeout_reg <= 1'b0;
            for (int p = 0; p < NPORTS; p++) begin
                rdata_reg[p] <= '0;
            end
        end else begin
            timeout_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (pick_valid) begin
                        grant_reg <= pick_idx;
                        rw_reg    <= i_rw[pick_idx];
                        addr_reg  <= i_address[pick_idx*ADDR_W +: ADDR_W];
                        wdata_reg <= i_wdata[pick_idx*DATA_W +: DATA_W];
                        timer_reg <= '0;
                    end
                end
                BUS: begin
                    if (i_bus_ready) begin
                        if (!rw_reg) rdata_reg[grant_reg] <= i_bus_rdata;
                    end else if (timeout_hit) begin
                        rdata_reg[grant_reg] <= TIMEOUT_DATA;
                        timeout_reg          <= 1'b1;
                    end else begin
                        timer_reg <= timer_reg + 1'b1;
                    end
                end
                ACK: begin
                    if (!i_request[grant_reg]) ptr_reg <= ptr_next;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        o_ready       = '0;
        o_busy        = '0;
        o_bus_request = 1'b0;
        o_bus_rw      = 1'b0;
        o_bus_address = '0;
        o_bus_wdata   = '0;
        case (state_reg)
            BUS: begin
                o_bus_request     = 1'b1;
                o_bus_rw          = rw_reg;
                o_bus_address     = addr_reg;
                o_bus_wdata       = wdata_reg;
                o_busy[grant_reg] = 1'b1;
            end
            ACK: begin
                o_ready[grant_reg] = 1'b1;
                o_busy[grant_reg]  = 1'b1;
            end
            default: ;
        endcase
    end

    assign o_timeout = timeout_reg;

    for (genvar gi = 0; gi < NPORTS; gi++) begin : g_rdata
        assign o_rdata[gi*DATA_W +: DATA_W] = rdata_reg[gi];
    end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Directed and randomized bench for bus_arbiter_n; a transaction-level model predicts
// winners, downstream contents, cycle counts and per-port read data.
module tb_bus_arbiter_n;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]    req, rw;
    logic [31:0]     addr [N];
    logic [31:0]     wdat [N];
    logic [N*32-1:0] addr_pk, wdata_pk;
    logic [N*32-1:0] rdata_pk;
    logic [N-1:0]    ready, busy;
    logic            bus_req, bus_rw, bus_ready, timeout;
    logic [31:0]     bus_addr, bus_wdata, bus_rdata;

    logic [N-1:0]    fix_req, fix_ready, fix_busy;
    logic [N*32-1:0] fix_rdata_pk;
    logic            fix_bus_req, fix_bus_rw, fix_timeout;
    logic [31:0]     fix_bus_addr, fix_bus_wdata;

    always_comb begin
        addr_pk  = '0;
        wdata_pk = '0;
        for (int p = 0; p < N; p++) begin
            addr_pk[p*32 +: 32]  = addr[p];
            wdata_pk[p*32 +: 32] = wdat[p];
        end
    end

    bus_arbiter_n #(.NPORTS(N), .ADDR_W(32), .DATA_W(32), .MODE(1), .TIMEOUT(16),
                    .TIMEOUT_DATA(32'hDEADBEEF)) u_dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_request(req), .i_rw(rw),
        .i_address(addr_pk), .i_wdata(wdata_pk), .o_rdata(rdata_pk),
        .o_ready(ready), .o_busy(busy), .o_bus_request(bus_req), .o_bus_rw(bus_rw),
        .o_bus_address(bus_addr), .o_bus_wdata(bus_wdata), .i_bus_ready(bus_ready),
        .i_bus_rdata(bus_rdata), .o_timeout(timeout)
    );

    // Fixed-priority instance with a zero-wait slave looped back on its own request.
    bus_arbiter_n #(.NPORTS(N), .ADDR_W(32), .DATA_W(32), .MODE(0), .TIMEOUT(0),
                    .TIMEOUT_DATA(32'hDEADBEEF)) u_fix (
        .i_clock(clk), .i_reset_n(rst_n), .i_request(fix_req), .i_rw(rw),
        .i_address(addr_pk), .i_wdata(wdata_pk), .o_rdata(fix_rdata_pk),
        .o_ready(fix_ready), .o_busy(fix_busy), .o_bus_request(fix_bus_req),
        .o_bus_rw(fix_bus_rw), .o_bus_address(fix_bus_addr), .o_bus_wdata(fix_bus_wdata),
        .i_bus_ready(fix_bus_req), .i_bus_rdata(bus_rdata), .o_timeout(fix_timeout)
    );

    int          checks = 0;
    int          errors = 0;
    int          ptr_m;
    logic [31:0] rd_m [N];
    int          order [$];

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic chk_rdata_all(input string tag);
        for (int p = 0; p < N; p++) chk(tag, rdata_pk[p*32 +: 32], rd_m[p]);
    endtask

    task automatic raise(input int p);
        rw[p]   = 1'($urandom_range(0, 1));
        addr[p] = $urandom;
        wdat[p] = $urandom;
        req[p]  = 1'b1;
    endtask

    // One complete transfer: arbitration, downstream phase, ACK, release.
    task automatic serve(input int lat, input logic [31:0] rdat, input bit to);
        int w, n, obs;
        logic [N-1:0] oh;
        w  = pick(req, ptr_m);
        oh = 4'b0001 << w;
        n  = 0;
        while (!bus_req && n < 10) begin
            tick();
            n++;
        end
        chk("grant_latency", n, 1);
        if (!bus_req) return;
        chk("busy_in_bus", busy, oh);
        obs = -1;
        for (int p = 0; p < N; p++) if (busy[p]) obs = p;
        order.push_back(obs);
        chk("bus_rw", bus_rw, rw[w]);
        chk("bus_address", bus_addr, addr[w]);
        chk("bus_wdata", bus_wdata, wdat[w]);
        n = 0;
        while (bus_req && n < 40) begin
            n++;
            if (!to && n == lat + 1) begin
                bus_ready = 1'b1;
                bus_rdata = rdat;
            end
            tick();
            bus_ready = 1'b0;
            bus_rdata = $urandom;
        end
        chk("bus_cycles", n, to ? 16 : lat + 1);
        chk("timeout_pulse", timeout, to);
        if (to) rd_m[w] = 32'hDEADBEEF;
        else if (!rw[w]) rd_m[w] = rdat;
        chk("ready_ack", ready, oh);
        chk("busy_ack", busy, oh);
        chk_rdata_all("rdata_ack");
        tick();
        chk("ready_held", ready, oh);
        chk("timeout_one_cycle", timeout, 0);
        req[w] = 1'b0;
        tick();
        chk("ready_release", ready, 0);
        chk("busy_release", busy, 0);
        ptr_m = (w + 1) % N;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        int exp_order [6];
        int n;
        exp_order = '{0, 1, 2, 3, 0, 1};
        rst_n = 1'b0; req = '0; rw = '0; fix_req = '0;
        bus_ready = 1'b0; bus_rdata = '0; ptr_m = 0;
        for (int p = 0; p < N; p++) begin
            addr[p] = '0; wdat[p] = '0; rd_m[p] = '0;
        end
        repeat (3) tick();
        chk("reset_bus_request", bus_req, 0);
        chk("reset_ready", ready, 0);
        chk("reset_busy", busy, 0);
        chk("reset_timeout", timeout, 0);
        chk_rdata_all("reset_rdata");
        rst_n = 1'b1;
        tick();

        // Single read on port 2 with a 3-wait slave.
        rw[2] = 1'b0; addr[2] = 32'h2000_0010; req[2] = 1'b1;
        serve(3, 32'h1234_5678, 0);
        chk("port2_rdata", rdata_pk[2*32 +: 32], 32'h1234_5678);

        // Pointer now at 3: ports 0 and 3 together, 3 goes first.
        order.delete();
        raise(0); raise(3);
        serve(0, $urandom, 0);
        serve(2, $urandom, 0);
        chk("ptr3_first", order[0], 3);
        chk("ptr3_second", order[1], 0);

        // Write on port 1 leaves its rdata slice untouched.
        rw[1] = 1'b1; addr[1] = 32'h1000_0040; wdat[1] = 32'hCAFE_F00D; req[1] = 1'b1;
        serve(1, 32'h5555_AAAA, 0);

        // Slave never answers: watchdog aborts.
        rw[0] = 1'b0; addr[0] = 32'h3000_0000; req[0] = 1'b1;
        serve(0, '0, 1);
        chk("timeout_rdata", rdata_pk[0*32 +: 32], 32'hDEADBEEF);

        // Ready outside BUS is ignored.
        bus_ready = 1'b1; bus_rdata = 32'h0BAD_0BAD;
        repeat (3) tick();
        chk("idle_bus_request", bus_req, 0);
        chk_rdata_all("idle_ready_ignored");
        bus_ready = 1'b0;

        // Reset in the middle of BUS.
        raise(3); raise(1);
        tick();
        chk("pre_reset_bus", bus_req, 1);
        rst_n = 1'b0;
        #1;
        chk("async_bus_request", bus_req, 0);
        chk("async_busy", busy, 0);
        chk("async_ready", ready, 0);
        for (int p = 0; p < N; p++) rd_m[p] = '0;
        chk_rdata_all("async_rdata");
        ptr_m = 0;
        tick();
        rst_n = 1'b1;
        order.delete();
        serve(0, $urandom, 0);
        serve(1, $urandom, 0);
        chk("post_reset_first", order[0], 1);
        chk("post_reset_second", order[1], 3);

        // All ports requesting continuously: round-robin order from pointer 0.
        order.delete();
        for (int p = 0; p < N; p++) raise(p);
        for (int i = 0; i < 6; i++) begin
            serve(1, $urandom, 0);
            for (int p = 0; p < N; p++) if (!req[p]) raise(p);
        end
        for (int i = 0; i < 6; i++) chk("rr_order", order[i], exp_order[i]);
        n = 0;
        while (req != 0 && n < 8) begin
            serve(1, $urandom, 0);
            n++;
        end

        // Randomized traffic.
        for (int it = 0; it < 24; it++) begin
            for (int p = 0; p < N; p++) if (!req[p] && $urandom_range(0, 1) == 1) raise(p);
            if (req == 0) raise(int'($urandom_range(0, N - 1)));
            serve(int'($urandom_range(0, 3)), $urandom, 0);
        end
        n = 0;
        while (req != 0 && n < 8) begin
            serve(0, $urandom, 0);
            n++;
        end

        // Fixed priority: every port requests, port 0 always wins.
        for (int r = 0; r < 3; r++) begin
            fix_req = 4'hF;
            n = 0;
            while (fix_ready == 0 && n < 10) begin
                tick();
                n++;
            end
            chk("fixed_ready", fix_ready, 4'b0001);
            fix_req = '0;
            tick();
            chk("fixed_release", fix_ready, 0);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
